// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for mem_ctrl: FSM states, busy/width codes,
// access-size decode and load extension.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_IF_RD,
      ST_MEM_RD,
      ST_MEM_WR
   } state_t;

   localparam logic [1:0] BUSY_IDLE = 2'b00;
   localparam logic [1:0] BUSY_IF   = 2'b01;
   localparam logic [1:0] BUSY_MEM  = 2'b10;

   localparam logic [1:0] WIDTH_B = 2'b00;
   localparam logic [1:0] WIDTH_H = 2'b01;

   // Width code 11 is deliberately folded into the 4-byte case.
   function automatic logic [2:0] width_bytes(input logic [1:0] width);
      case (width)
         WIDTH_B: return 3'd1;
         WIDTH_H: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] data,
                                               input logic [1:0]  width,
                                               input logic        sign_ext);
      logic [31:0] result;
      case (width)
         WIDTH_B: result = {{24{sign_ext & data[7]}}, data[7:0]};
         WIDTH_H: result = {{16{sign_ext & data[15]}}, data[15:0]};
         default: result = data;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-wide RAM port arbiter serialising IF fetches and MEM loads/stores.
// Optional I/O write throttling is enabled by defining MEMCTRL_IO_STALL_EN.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int IO_ADDR_BIT = 17
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  if_req_in,
   input  logic [ADDR_WIDTH-1:0] if_addr_in,
   output logic                  if_done_out,
   output logic [31:0]           if_inst_out,
   input  logic                  read_req_in,
   input  logic                  write_req_in,
   input  logic [ADDR_WIDTH-1:0] mem_addr_in,
   input  logic [31:0]           mem_val_in,
   input  logic [1:0]            mem_width_in,
   input  logic                  mem_signed_in,
   output logic                  mem_done_out,
   output logic [31:0]           mem_val_read_out,
   output logic [1:0]            memctrl_busy_out,
`ifdef MEMCTRL_IO_STALL_EN
   input  logic                  io_buffer_full_in,
`endif
   output logic [ADDR_WIDTH-1:0] ram_addr_out,
   output logic                  ram_wr_out,
   output logic [7:0]            ram_data_out,
   input  logic [7:0]            ram_data_in
);

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [1:0]            width_q, width_d;
   logic                  signed_q, signed_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           asm_q, asm_d;
   logic                  if_done_q, if_done_d;
   logic                  mem_done_q, mem_done_d;

   logic       io_full;
   logic       io_stall;
   logic [2:0] cur_bytes;
   logic [1:0] cap_idx;
   logic       start_mem;
   logic       start_if;
   logic       capture;
   logic       addr_phase;

`ifdef MEMCTRL_IO_STALL_EN
   assign io_full = io_buffer_full_in;
`else
   assign io_full = 1'b0;
`endif

   assign io_stall  = (state_q == ST_MEM_WR) && base_q[IO_ADDR_BIT] && io_full;
   assign cur_bytes = (state_q == ST_IF_RD) ? 3'd4 : width_bytes(width_q);
   // Read data lags its address by one cycle, so counter k captures byte k-1.
   assign cap_idx   = cnt_q[1:0] - 2'd1;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         base_q     <= '0;
         width_q    <= '0;
         signed_q   <= 1'b0;
         wdata_q    <= '0;
         asm_q      <= '0;
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         base_q     <= base_d;
         width_q    <= width_d;
         signed_q   <= signed_d;
         wdata_q    <= wdata_d;
         asm_q      <= asm_d;
         if_done_q  <= if_done_d;
         mem_done_q <= mem_done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      base_d     = base_q;
      width_d    = width_q;
      signed_d   = signed_q;
      wdata_d    = wdata_q;
      asm_d      = asm_q;
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      start_mem  = 1'b0;
      start_if   = 1'b0;
      capture    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A done pulse means the requester is still lowering its level.
            if (!if_done_q && !mem_done_q) begin
               if (read_req_in || write_req_in) begin
                  start_mem = 1'b1;
               end else if (if_req_in) begin
                  start_if = 1'b1;
               end
            end
         end
         ST_IF_RD: begin
            if (read_req_in || write_req_in) begin
               start_mem = 1'b1;
            end else if (!if_req_in) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               capture = (cnt_q != 3'd0);
               if (cnt_q == cur_bytes) begin
                  state_d   = ST_IDLE;
                  cnt_d     = '0;
                  if_done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         ST_MEM_RD: begin
            capture = (cnt_q != 3'd0);
            if (cnt_q == cur_bytes) begin
               state_d    = ST_IDLE;
               cnt_d      = '0;
               mem_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         ST_MEM_WR: begin
            if (!io_stall) begin
               if (cnt_q == cur_bytes - 3'd1) begin
                  state_d    = ST_IDLE;
                  cnt_d      = '0;
                  mem_done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (capture) begin
         asm_d[{cap_idx, 3'b000} +: 8] = ram_data_in;
      end

      // A new access always restarts from byte 0 with a clean assembly register.
      if (start_mem) begin
         state_d  = read_req_in ? ST_MEM_RD : ST_MEM_WR;
         cnt_d    = '0;
         base_d   = mem_addr_in;
         width_d  = mem_width_in;
         signed_d = mem_signed_in;
         wdata_d  = mem_val_in;
         asm_d    = '0;
      end else if (start_if) begin
         state_d = ST_IF_RD;
         cnt_d   = '0;
         base_d  = if_addr_in;
         asm_d   = '0;
      end
   end

   always_comb begin
      memctrl_busy_out = BUSY_IDLE;
      addr_phase       = 1'b0;
      case (state_q)
         ST_IF_RD: begin
            memctrl_busy_out = BUSY_IF;
            addr_phase       = (cnt_q < cur_bytes);
         end
         ST_MEM_RD: begin
            memctrl_busy_out = BUSY_MEM;
            addr_phase       = (cnt_q < cur_bytes);
         end
         ST_MEM_WR: begin
            memctrl_busy_out = BUSY_MEM;
            addr_phase       = 1'b1;
         end
         default: begin
            memctrl_busy_out = BUSY_IDLE;
            addr_phase       = 1'b0;
         end
      endcase
   end

   assign ram_addr_out     = addr_phase ? (base_q + ADDR_WIDTH'(cnt_q)) : '0;
   assign ram_wr_out       = (state_q == ST_MEM_WR) && !io_stall;
   assign ram_data_out     = (state_q == ST_MEM_WR) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
   assign if_done_out      = if_done_q;
   assign if_inst_out      = if_done_q ? asm_q : 32'h0;
   assign mem_done_out     = mem_done_q;
   assign mem_val_read_out = mem_done_q ? extend_load(asm_q, width_q, signed_q) : 32'h0;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a small byte-RAM model.
// The I/O stall scenario is built only when MEMCTRL_IO_STALL_EN is defined.
module tb_mem_ctrl;

   logic        clk_in;
   logic        rst_in;
   logic        if_req_in;
   logic [31:0] if_addr_in;
   logic        if_done_out;
   logic [31:0] if_inst_out;
   logic        read_req_in;
   logic        write_req_in;
   logic [31:0] mem_addr_in;
   logic [31:0] mem_val_in;
   logic [1:0]  mem_width_in;
   logic        mem_signed_in;
   logic        mem_done_out;
   logic [31:0] mem_val_read_out;
   logic [1:0]  memctrl_busy_out;
   logic [31:0] ram_addr_out;
   logic        ram_wr_out;
   logic [7:0]  ram_data_out;
   logic [7:0]  ram_data_in;
`ifdef MEMCTRL_IO_STALL_EN
   logic        ioFull;
`endif

   int assertCount = 0;
   int failCount   = 0;

   logic [7:0] ram [0:255];
   logic [7:0] swBytes [0:3];

   mem_ctrl dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .if_req_in        (if_req_in),
      .if_addr_in       (if_addr_in),
      .if_done_out      (if_done_out),
      .if_inst_out      (if_inst_out),
      .read_req_in      (read_req_in),
      .write_req_in     (write_req_in),
      .mem_addr_in      (mem_addr_in),
      .mem_val_in       (mem_val_in),
      .mem_width_in     (mem_width_in),
      .mem_signed_in    (mem_signed_in),
      .mem_done_out     (mem_done_out),
      .mem_val_read_out (mem_val_read_out),
      .memctrl_busy_out (memctrl_busy_out),
`ifdef MEMCTRL_IO_STALL_EN
      .io_buffer_full_in(ioFull),
`endif
      .ram_addr_out     (ram_addr_out),
      .ram_wr_out       (ram_wr_out),
      .ram_data_out     (ram_data_out),
      .ram_data_in      (ram_data_in)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Byte RAM: read data appears one cycle after the address; contents reload while in reset.
   always @(posedge clk_in) begin
      if (!rst_in) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
         ram[8'h00]  <= 8'h13;
         ram[8'h01]  <= 8'h05;
         ram[8'h08]  <= 8'h34;
         ram[8'h09]  <= 8'h92;
         ram[8'h20]  <= 8'h80;
         ram[8'hFF]  <= 8'hCD;
         ram_data_in <= 8'h00;
      end else begin
         ram_data_in <= ram[ram_addr_out[7:0]];
         if (ram_wr_out) ram[ram_addr_out[7:0]] <= ram_data_out;
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic applyStimulus(input logic        ifReq,
                                input logic [31:0] ifAddr,
                                input logic        rdReq,
                                input logic        wrReq,
                                input logic [31:0] addr,
                                input logic [31:0] val,
                                input logic [1:0]  width,
                                input logic        sgn);
      if_req_in     = ifReq;
      if_addr_in    = ifAddr;
      read_req_in   = rdReq;
      write_req_in  = wrReq;
      mem_addr_in   = addr;
      mem_val_in    = val;
      mem_width_in  = width;
      mem_signed_in = sgn;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      swBytes[0] = 8'hEF;
      swBytes[1] = 8'hBE;
      swBytes[2] = 8'hAD;
      swBytes[3] = 8'hDE;
`ifdef MEMCTRL_IO_STALL_EN
      ioFull = 1'b0;
`endif
      rst_in = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      tick();
      tick();
      checkOutput("reset_busy", 32'(memctrl_busy_out), 32'h0);
      checkOutput("reset_if_done", 32'(if_done_out), 32'h0);
      checkOutput("reset_mem_done", 32'(mem_done_out), 32'h0);
      checkOutput("reset_ram_addr", ram_addr_out, 32'h0);
      checkOutput("reset_ram_wr", 32'(ram_wr_out), 32'h0);
      checkOutput("reset_ram_data", 32'(ram_data_out), 32'h0);
      checkOutput("reset_if_inst", if_inst_out, 32'h0);
      checkOutput("reset_mem_val", mem_val_read_out, 32'h0);
      rst_in = 1'b1;
      tick();

      $display("[TB] IF fetch at 0x1000");
      applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      tick();
      checkOutput("if1_busy_t1", 32'(memctrl_busy_out), 32'h1);
      checkOutput("if1_addr_t1", ram_addr_out, 32'h1000);
      checkOutput("if1_wr_t1", 32'(ram_wr_out), 32'h0);
      tick();
      checkOutput("if1_addr_t2", ram_addr_out, 32'h1001);
      tick();
      tick();
      checkOutput("if1_addr_t4", ram_addr_out, 32'h1003);
      tick();
      checkOutput("if1_busy_t5", 32'(memctrl_busy_out), 32'h1);
      checkOutput("if1_done_t5", 32'(if_done_out), 32'h0);
      tick();
      checkOutput("if1_done_t6", 32'(if_done_out), 32'h1);
      checkOutput("if1_inst_t6", if_inst_out, 32'h0000_0513);
      checkOutput("if1_busy_t6", 32'(memctrl_busy_out), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      tick();
      checkOutput("if1_done_t7", 32'(if_done_out), 32'h0);

      $display("[TB] lb signed and unsigned at 0x20");
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 2'b00, 1'b1);
      tick();
      checkOutput("lb_busy_t1", 32'(memctrl_busy_out), 32'h2);
      checkOutput("lb_addr_t1", ram_addr_out, 32'h20);
      tick();
      checkOutput("lb_busy_t2", 32'(memctrl_busy_out), 32'h2);
      checkOutput("lb_done_t2", 32'(mem_done_out), 32'h0);
      tick();
      checkOutput("lbs_done", 32'(mem_done_out), 32'h1);
      checkOutput("lbs_val", mem_val_read_out, 32'hFFFF_FF80);
      checkOutput("lbs_busy_done", 32'(memctrl_busy_out), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 2'b00, 1'b0);
      tick();
      checkOutput("lbu_not_in_done_cycle", 32'(memctrl_busy_out), 32'h0);
      tick();
      checkOutput("lbu_busy_t1", 32'(memctrl_busy_out), 32'h2);
      tick();
      tick();
      checkOutput("lbu_done", 32'(mem_done_out), 32'h1);
      checkOutput("lbu_val", mem_val_read_out, 32'h0000_0080);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      tick();

      $display("[TB] sw 0xDEADBEEF at 0x40");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 2'b10, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick();
         checkOutput($sformatf("sw_addr_%0d", k), ram_addr_out, 32'h40 + 32'(k));
         checkOutput($sformatf("sw_data_%0d", k), 32'(ram_data_out), 32'(swBytes[k]));
         checkOutput($sformatf("sw_wr_%0d", k), 32'(ram_wr_out), 32'h1);
         checkOutput($sformatf("sw_done_%0d", k), 32'(mem_done_out), 32'h0);
      end
      tick();
      checkOutput("sw_done_t5", 32'(mem_done_out), 32'h1);
      checkOutput("sw_wr_t5", 32'(ram_wr_out), 32'h0);
      checkOutput("sw_busy_t5", 32'(memctrl_busy_out), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      tick();

      $display("[TB] width code 11 load at 0x40");
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 2'b11, 1'b1);
      repeat (5) tick();
      checkOutput("w11_busy_t5", 32'(memctrl_busy_out), 32'h2);
      checkOutput("w11_done_t5", 32'(mem_done_out), 32'h0);
      tick();
      checkOutput("w11_done_t6", 32'(mem_done_out), 32'h1);
      checkOutput("w11_val", mem_val_read_out, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      tick();

      $display("[TB] lhu wrapping at 0xFFFFFFFF");
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 2'b01, 1'b0);
      tick();
      checkOutput("wrap_addr_t1", ram_addr_out, 32'hFFFF_FFFF);
      tick();
      checkOutput("wrap_addr_t2", ram_addr_out, 32'h0000_0000);
      tick();
      tick();
      checkOutput("wrap_done", 32'(mem_done_out), 32'h1);
      checkOutput("wrap_val", mem_val_read_out, 32'h0000_13CD);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      tick();

      $display("[TB] IF preempted by lh at 0x8");
      applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      tick();
      tick();
      tick();
      tick();
      checkOutput("pre_if_addr", ram_addr_out, 32'h1003);
      checkOutput("pre_if_busy", 32'(memctrl_busy_out), 32'h1);
      applyStimulus(1'b1, 32'h1000, 1'b1, 1'b0, 32'h8, 32'h0, 2'b01, 1'b1);
      tick();
      checkOutput("pre_mem_busy", 32'(memctrl_busy_out), 32'h2);
      checkOutput("pre_mem_addr0", ram_addr_out, 32'h8);
      checkOutput("pre_no_if_done", 32'(if_done_out), 32'h0);
      tick();
      checkOutput("pre_mem_addr1", ram_addr_out, 32'h9);
      tick();
      tick();
      checkOutput("pre_mem_done", 32'(mem_done_out), 32'h1);
      checkOutput("pre_mem_val", mem_val_read_out, 32'hFFFF_9234);
      checkOutput("pre_if_done_at_mem_done", 32'(if_done_out), 32'h0);
      applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      tick();
      checkOutput("pre_gap_busy", 32'(memctrl_busy_out), 32'h0);
      tick();
      checkOutput("pre_restart_busy", 32'(memctrl_busy_out), 32'h1);
      checkOutput("pre_restart_addr", ram_addr_out, 32'h1000);
      repeat (4) tick();
      checkOutput("pre_restart_not_done", 32'(if_done_out), 32'h0);
      tick();
      checkOutput("pre_restart_done", 32'(if_done_out), 32'h1);
      checkOutput("pre_restart_inst", if_inst_out, 32'h0000_0513);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      tick();

      $display("[TB] simultaneous IF, read and write requests");
      applyStimulus(1'b1, 32'h1000, 1'b1, 1'b1, 32'h20, 32'h5A, 2'b00, 1'b0);
      tick();
      checkOutput("arb_busy_t1", 32'(memctrl_busy_out), 32'h2);
      checkOutput("arb_wr_t1", 32'(ram_wr_out), 32'h0);
      checkOutput("arb_addr_t1", ram_addr_out, 32'h20);
      tick();
      tick();
      checkOutput("arb_rd_done", 32'(mem_done_out), 32'h1);
      checkOutput("arb_rd_val", mem_val_read_out, 32'h0000_0080);
      applyStimulus(1'b1, 32'h1000, 1'b0, 1'b1, 32'h50, 32'h5A, 2'b00, 1'b0);
      tick();
      checkOutput("arb_gap_busy", 32'(memctrl_busy_out), 32'h0);
      checkOutput("arb_gap_wr", 32'(ram_wr_out), 32'h0);
      tick();
      checkOutput("arb_wr_busy", 32'(memctrl_busy_out), 32'h2);
      checkOutput("arb_wr_en", 32'(ram_wr_out), 32'h1);
      checkOutput("arb_wr_addr", ram_addr_out, 32'h50);
      checkOutput("arb_wr_data", 32'(ram_data_out), 32'h5A);
      tick();
      checkOutput("arb_wr_done", 32'(mem_done_out), 32'h1);
      checkOutput("arb_wr_off", 32'(ram_wr_out), 32'h0);
      applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      tick();
      checkOutput("arb_if_gap_busy", 32'(memctrl_busy_out), 32'h0);
      tick();
      checkOutput("arb_if_busy", 32'(memctrl_busy_out), 32'h1);
      checkOutput("arb_if_addr", ram_addr_out, 32'h1000);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      tick();
      checkOutput("flush_busy", 32'(memctrl_busy_out), 32'h0);
      checkOutput("flush_no_done_a", 32'(if_done_out), 32'h0);
      tick();
      checkOutput("flush_no_done_b", 32'(if_done_out), 32'h0);

`ifdef MEMCTRL_IO_STALL_EN
      $display("[TB] sb to I/O region with buffer full");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0003_0000, 32'hA5, 2'b00, 1'b0);
      ioFull = 1'b1;
      tick();
      checkOutput("io_stall_busy", 32'(memctrl_busy_out), 32'h2);
      checkOutput("io_stall_wr_t1", 32'(ram_wr_out), 32'h0);
      checkOutput("io_stall_addr", ram_addr_out, 32'h0003_0000);
      tick();
      checkOutput("io_stall_wr_t2", 32'(ram_wr_out), 32'h0);
      tick();
      checkOutput("io_stall_wr_t3", 32'(ram_wr_out), 32'h0);
      checkOutput("io_stall_done_t3", 32'(mem_done_out), 32'h0);
      tick();
      ioFull = 1'b0;
      #1;
      checkOutput("io_resume_wr", 32'(ram_wr_out), 32'h1);
      checkOutput("io_resume_data", 32'(ram_data_out), 32'hA5);
      checkOutput("io_resume_not_done", 32'(mem_done_out), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      tick();
      checkOutput("io_done", 32'(mem_done_out), 32'h1);
      tick();
`endif

      $display("[TB] reset during sw byte 2");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h60, 32'h1122_3344, 2'b10, 1'b0);
      tick();
      tick();
      tick();
      checkOutput("rst_pre_addr", ram_addr_out, 32'h62);
      checkOutput("rst_pre_data", 32'(ram_data_out), 32'h22);
      rst_in = 1'b0;
      #1;
      checkOutput("rst_busy", 32'(memctrl_busy_out), 32'h0);
      checkOutput("rst_wr", 32'(ram_wr_out), 32'h0);
      checkOutput("rst_addr", ram_addr_out, 32'h0);
      checkOutput("rst_data", 32'(ram_data_out), 32'h0);
      checkOutput("rst_done", 32'(mem_done_out), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      tick();
      checkOutput("rst_hold_done", 32'(mem_done_out), 32'h0);
      rst_in = 1'b1;
      tick();
      tick();
      checkOutput("rst_after_done", 32'(mem_done_out), 32'h0);
      checkOutput("rst_after_busy", 32'(memctrl_busy_out), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
